// File: rtl/high_priority_scan_pkg.sv
// Shared types and constants for the sequential priority scan encoder.
package high_priority_scan_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    localparam int unsigned PRIO_LSB_FIRST = 0;
    localparam int unsigned PRIO_MSB_FIRST = 1;

endpackage

// File: rtl/priority_index_encoder.sv
// Combinational priority encoder: index of the highest-priority set bit of a vector.
module priority_index_encoder
    import high_priority_scan_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PRIORITY_MODE = PRIO_MSB_FIRST,
    localparam int unsigned INDEX_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0]  vector,
    output logic [INDEX_WIDTH-1:0] index,
    output logic                   any_set
);

    // Later matches overwrite earlier ones, so the scan direction sets the winner.
    always_comb begin
        index = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
            if (PRIORITY_MODE == PRIO_MSB_FIRST) begin
                if (vector[INDEX_WIDTH'(i)]) begin
                    index = INDEX_WIDTH'(i);
                end
            end else begin
                if (vector[INDEX_WIDTH'(DATA_WIDTH - 1 - i)]) begin
                    index = INDEX_WIDTH'(DATA_WIDTH - 1 - i);
                end
            end
        end
    end

    assign any_set = |vector;

endmodule

// File: rtl/high_priority_scan_encoder.sv
// Sequential priority encoder: accepts a request vector, then emits each set bit's
// index in priority order over a valid/ready output handshake.
module high_priority_scan_encoder
    import high_priority_scan_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned PRIORITY_MODE = PRIO_MSB_FIRST,
    localparam int unsigned INDEX_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                   Clock_In,
    input  logic                   Reset_In,
    input  logic                   Enable_In,
    input  logic [DATA_WIDTH-1:0]  Data_In,
    input  logic                   Data_Valid_In,
    output logic                   Data_Ready_Out,
    output logic [INDEX_WIDTH-1:0] Encoded_Value_Out,
    output logic                   Encoded_Valid_Out,
    input  logic                   Encoded_Ready_In,
    output logic                   Encoded_Last_Out,
    output logic [INDEX_WIDTH:0]   Remaining_Count_Out,
    output logic                   Zero_Flag_Out
);

    scan_state_t             state_q;
    logic [DATA_WIDTH-1:0]   pending_q;
    logic [INDEX_WIDTH:0]    count_q;
    logic                    zero_q;
    logic [INDEX_WIDTH-1:0]  top_index;
    logic                    any_set;
    logic                    accept;
    logic                    scan_valid;
    logic                    pop;
    logic                    count_is_one;

    priority_index_encoder #(
        .DATA_WIDTH    (DATA_WIDTH),
        .PRIORITY_MODE (PRIORITY_MODE)
    ) u_index (
        .vector  (pending_q),
        .index   (top_index),
        .any_set (any_set)
    );

    assign Data_Ready_Out = (state_q == IDLE) & Enable_In & ~Reset_In;
    assign accept         = Data_Valid_In & Data_Ready_Out;
    assign count_is_one   = (count_q == (INDEX_WIDTH+1)'(1));

    // Outputs derive from registered state only, so they hold steady under backpressure.
    assign scan_valid          = (state_q == SCAN) & Enable_In & any_set;
    assign pop                 = scan_valid & Encoded_Ready_In;
    assign Encoded_Valid_Out   = scan_valid;
    assign Encoded_Value_Out   = scan_valid ? top_index : '0;
    assign Encoded_Last_Out    = scan_valid & count_is_one;
    assign Remaining_Count_Out = scan_valid ? count_q : '0;
    assign Zero_Flag_Out       = zero_q & Enable_In;

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
            zero_q    <= 1'b0;
        end else begin
            zero_q <= accept & ~(|Data_In);
            if (accept && (|Data_In)) begin
                state_q   <= SCAN;
                pending_q <= Data_In;
                count_q   <= (INDEX_WIDTH+1)'($countones(Data_In));
            end else if (pop) begin
                pending_q <= pending_q & ~(DATA_WIDTH'(1) << top_index);
                count_q   <= count_q - (INDEX_WIDTH+1)'(1);
                if (count_is_one) begin
                    state_q <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_high_priority_scan_encoder.sv
// Bench for high_priority_scan_encoder: an 8-bit MSB-first and a 16-bit LSB-first instance
// share handshake inputs and are each compared every cycle against a set-based model.
module tb_high_priority_scan_encoder;
    import high_priority_scan_pkg::*;

    logic        clk = 1'b0;
    logic        rst, en, dv, rdy;
    logic [7:0]  din_a;
    logic [15:0] din_b;

    logic        ready_a, valid_a, last_a, zero_a;
    logic [2:0]  value_a;
    logic [3:0]  count_a;
    logic        ready_b, valid_b, last_b, zero_b;
    logic [3:0]  value_b;
    logic [4:0]  count_b;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Model state per instance: 0 = 8-bit MSB first, 1 = 16-bit LSB first.
    bit          busy [2];
    int unsigned vec  [2];
    bit          zp   [2];

    always #5 clk = ~clk;

    high_priority_scan_encoder #(.DATA_WIDTH(8), .PRIORITY_MODE(PRIO_MSB_FIRST)) dut_a (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Data_In(din_a), .Data_Valid_In(dv),
        .Data_Ready_Out(ready_a), .Encoded_Value_Out(value_a), .Encoded_Valid_Out(valid_a),
        .Encoded_Ready_In(rdy), .Encoded_Last_Out(last_a), .Remaining_Count_Out(count_a),
        .Zero_Flag_Out(zero_a)
    );

    high_priority_scan_encoder #(.DATA_WIDTH(16), .PRIORITY_MODE(PRIO_LSB_FIRST)) dut_b (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Data_In(din_b), .Data_Valid_In(dv),
        .Data_Ready_Out(ready_b), .Encoded_Value_Out(value_b), .Encoded_Valid_Out(valid_b),
        .Encoded_Ready_In(rdy), .Encoded_Last_Out(last_b), .Remaining_Count_Out(count_b),
        .Zero_Flag_Out(zero_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    // Highest-priority pending index from plain arithmetic on the pending set.
    function automatic int unsigned exp_index(input int k, input int unsigned v);
        if (k == 0) return $clog2(v + 1) - 1;
        return $clog2(v & (~v + 1));
    endfunction

    task automatic cmp_dut(input int k, input string p,
                           input logic [31:0] g_ready, input logic [31:0] g_valid,
                           input logic [31:0] g_value, input logic [31:0] g_last,
                           input logic [31:0] g_count, input logic [31:0] g_zero);
        bit          e_valid;
        int unsigned n;
        e_valid = busy[k] && en;
        n       = $countones(vec[k]);
        check({p, ".ready"}, g_ready, (!busy[k] && en && !rst) ? 1 : 0);
        check({p, ".valid"}, g_valid, e_valid ? 1 : 0);
        check({p, ".value"}, g_value, e_valid ? exp_index(k, vec[k]) : 0);
        check({p, ".last"},  g_last,  (e_valid && n == 1) ? 1 : 0);
        check({p, ".count"}, g_count, e_valid ? n : 0);
        check({p, ".zero"},  g_zero,  (zp[k] && en) ? 1 : 0);
    endtask

    // One clock cycle: drive inputs, compare, then advance the model on the rising edge.
    task automatic cyc(input logic e, input logic r, input logic v, input logic rd,
                       input logic [7:0] da, input logic [15:0] db);
        int unsigned d;
        bit          acc, pop, znew;
        en = e; rst = r; dv = v; rdy = rd; din_a = da; din_b = db;
        if (r) begin
            for (int k = 0; k < 2; k++) begin
                busy[k] = 0; vec[k] = 0; zp[k] = 0;
            end
        end
        #1;
        cmp_dut(0, "a", ready_a, valid_a, value_a, last_a, count_a, zero_a);
        cmp_dut(1, "b", ready_b, valid_b, value_b, last_b, count_b, zero_b);
        @(posedge clk);
        if (!r) begin
            for (int k = 0; k < 2; k++) begin
                d    = (k == 0) ? 32'(da) : 32'(db);
                acc  = !busy[k] && e && v;
                pop  = busy[k] && e && rd;
                znew = acc && d == 0;
                if (acc && d != 0) begin
                    busy[k] = 1;
                    vec[k]  = d;
                end else if (pop) begin
                    vec[k] = vec[k] & ~(32'd1 << exp_index(k, vec[k]));
                    if (vec[k] == 0) busy[k] = 0;
                end
                zp[k] = znew;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [15:0] rb;
        en = 1; rst = 1; dv = 0; rdy = 0; din_a = '0; din_b = '0;

        cyc(1, 1, 0, 0, 8'h00, 16'h0000);
        cyc(1, 1, 0, 0, 8'h00, 16'h0000);

        // A5 in both priority orders, consumer always ready, then the idle bubble
        cyc(1, 0, 1, 1, 8'hA5, 16'h00A5);
        repeat (6) cyc(1, 0, 0, 1, 8'h00, 16'h0000);

        // backpressure for three cycles on a two-bit vector
        cyc(1, 0, 1, 0, 8'h81, 16'h0081);
        repeat (3) cyc(1, 0, 0, 0, 8'h00, 16'h0000);
        repeat (3) cyc(1, 0, 0, 1, 8'h00, 16'h0000);

        // all-zero vector
        cyc(1, 0, 1, 1, 8'h00, 16'h0000);
        repeat (2) cyc(1, 0, 0, 1, 8'h00, 16'h0000);

        // full vector, two pops, then asynchronous reset mid-cycle
        cyc(1, 0, 1, 1, 8'hFF, 16'hFFFF);
        repeat (2) cyc(1, 0, 0, 1, 8'h00, 16'h0000);
        cyc(1, 1, 0, 1, 8'h00, 16'h0000);
        repeat (3) cyc(1, 0, 0, 1, 8'h00, 16'h0000);

        // enable low mid-scan; single-bit top vector on the 16-bit instance
        cyc(1, 0, 1, 1, 8'hA5, 16'h8000);
        cyc(1, 0, 0, 1, 8'h00, 16'h0000);
        repeat (2) cyc(0, 0, 1, 1, 8'h0F, 16'h0F0F);
        repeat (5) cyc(1, 0, 0, 1, 8'h00, 16'h0000);

        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            ra = 8'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ra = '0;
            if ($urandom_range(0, 7) == 0) rb = '0;
            cyc(($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
                ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
                1'($urandom), ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
